// File: rtl/laser_frame_sequencer_if.sv
// Laser frame sequencer bus: camera sync, run controls and laser enables.
// The master side drives V_SYNC/EN/CH_MASK; the sequencer is the slave.
interface laser_frame_sequencer_if #(
  parameter int N_CH = 2
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            V_SYNC;
  logic            EN;
  logic [N_CH-1:0] CH_MASK;
  logic [N_CH-1:0] SYNC;
  logic [CW-1:0]   CUR_CH;
  logic            FRAME_TICK;

  modport master (
    output V_SYNC, EN, CH_MASK,
    input  SYNC, CUR_CH, FRAME_TICK
  );

  modport slave (
    input  V_SYNC, EN, CH_MASK,
    output SYNC, CUR_CH, FRAME_TICK
  );
endinterface

// File: rtl/laser_frame_sequencer.sv
// Steps a one-hot laser enable across masked channels on each camera frame.
// Optional all-off guard after every accepted V_SYNC rising edge.
module laser_frame_sequencer #(
  parameter int N_CH          = 2,
  parameter int FRAMES_PER_CH = 1,
  parameter int GUARD_CYCLES  = 0,
  parameter int SYNC_STAGES   = 2
) (
  input logic                   CLK,
  input logic                   RST_N,
  laser_frame_sequencer_if.slave bus
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [7:0] FLAST = 8'(FRAMES_PER_CH - 1);
  localparam logic [15:0] GLOAD =
    (GUARD_CYCLES > 0) ? 16'(GUARD_CYCLES - 1) : 16'd0;
  localparam bit HAS_GUARD = (GUARD_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, GUARD, ON} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   vs_prev_q;
  logic                   armed_q;
  logic                   vs_s;
  logic                   vs_edge;
  logic                   mask_any;

  state_t          state_q;
  logic [CW-1:0]   ch_q;
  logic [7:0]      fcnt_q;
  logic [15:0]     gcnt_q;
  logic [N_CH-1:0] las_q;
  logic            tick_q;

  logic [CW-1:0] low_ch;
  logic [CW-1:0] nxt_ch;
  logic [CW-1:0] ch_d;
  logic [7:0]    fcnt_d;
  logic          hit_lo;
  logic          hit_nx;

  function automatic logic [N_CH-1:0] oh(input logic [CW-1:0] c);
    oh = N_CH'(1) << c;
  endfunction

  assign vs_s     = sync_q[SYNC_STAGES-1];
  assign vs_edge  = armed_q & vs_s & ~vs_prev_q;
  assign mask_any = |bus.CH_MASK;

  // fill_q marks when vs_s holds a real sample, so a V_SYNC already
  // high at reset release cannot arm the detector through reset zeros.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q    <= '0;
      fill_q    <= '0;
      vs_prev_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.V_SYNC};
      fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      vs_prev_q <= vs_s;
      if (fill_q[SYNC_STAGES-1] && !vs_s) armed_q <= 1'b1;
    end
  end

  always_comb begin
    low_ch = '0;
    hit_lo = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!hit_lo && bus.CH_MASK[i]) begin
        low_ch = CW'(i);
        hit_lo = 1'b1;
      end
    end
  end

  // Next set bit above ch, then wrap; stays on ch if it is alone.
  always_comb begin
    nxt_ch = ch_q;
    hit_nx = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!hit_nx && bus.CH_MASK[i] && i > int'(ch_q)) begin
        nxt_ch = CW'(i);
        hit_nx = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!hit_nx && bus.CH_MASK[i] && i < int'(ch_q)) begin
        nxt_ch = CW'(i);
        hit_nx = 1'b1;
      end
    end
  end

  always_comb begin
    ch_d   = ch_q;
    fcnt_d = fcnt_q + 8'd1;
    if (state_q == IDLE) begin
      ch_d   = low_ch;
      fcnt_d = 8'd0;
    end else if (fcnt_q == FLAST) begin
      ch_d   = nxt_ch;
      fcnt_d = 8'd0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ch_q    <= '0;
      fcnt_q  <= 8'd0;
      gcnt_q  <= 16'd0;
      las_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (!bus.EN || (vs_edge && !mask_any)) begin
        state_q <= IDLE;
        ch_q    <= '0;
        fcnt_q  <= 8'd0;
        gcnt_q  <= 16'd0;
        las_q   <= '0;
      end else if (vs_edge) begin
        tick_q <= 1'b1;
        ch_q   <= ch_d;
        fcnt_q <= fcnt_d;
        if (HAS_GUARD) begin
          state_q <= GUARD;
          gcnt_q  <= GLOAD;
          las_q   <= '0;
        end else begin
          state_q <= ON;
          las_q   <= oh(ch_d) & bus.CH_MASK;
        end
      end else begin
        unique case (state_q)
          IDLE: las_q <= '0;
          GUARD: begin
            if (gcnt_q == 16'd0) begin
              state_q <= ON;
              las_q   <= oh(ch_q) & bus.CH_MASK;
            end else begin
              gcnt_q <= gcnt_q - 16'd1;
            end
          end
          ON: las_q <= oh(ch_q) & bus.CH_MASK;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.SYNC       = las_q;
  assign bus.CUR_CH     = ch_q;
  assign bus.FRAME_TICK = tick_q;
endmodule

// File: doc/laser_frame_sequencer.md
Name: laser_frame_sequencer

Overview:
Parametrised successor to the two-laser alternating V_SYNC controller. Runs in the CLK domain and synchronises the camera V_SYNC. Steps a one-hot laser enable across N_CH channels, holding each channel on for FRAMES_PER_CH frames. Supports a channel mask, a run enable and an optional all-off guard interval after each frame edge. Sits between the imager V_SYNC output and the laser driver enable pins.

Parameters:
N_CH, 2, number of laser channels (2..16).
FRAMES_PER_CH, 1, consecutive frames each channel stays selected (1..255).
GUARD_CYCLES, 0, CLK cycles all lasers are forced off after each accepted frame edge (0..65535).
SYNC_STAGES, 2, V_SYNC synchroniser depth (>=2).

Ports:
CLK  in  1  system clock.
RST_N  in  1  reset, asynchronous, active-low.
V_SYNC  in  1  camera frame sync, asynchronous to CLK; frame starts on its rising edge.
EN  in  1  run enable, synchronous to CLK.
CH_MASK  in  N_CH  channels taking part in the rotation, synchronous to CLK.
SYNC  out  N_CH  laser enables; one-hot or all-zero, registered.
CUR_CH  out  max(1,clog2(N_CH))  index of the selected channel; 0 in IDLE.
FRAME_TICK  out  1  one-cycle pulse per accepted frame edge.

Behaviour:
- Reset, asynchronous while RST_N=0:
  - SYNC=0, CUR_CH=0, FRAME_TICK=0.
  - State IDLE, frame counter=0, guard counter=0.
  - Synchroniser flops=0, edge-arm flag=0.
- Edge detect:
  - V_SYNC passes through SYNC_STAGES flops; vs_s is the last stage.
  - Arm flag sets on the first cycle vs_s=0 after reset. This blocks a spurious edge when V_SYNC is already high at reset release.
  - edge = armed & vs_s & ~vs_prev.
- Accepted edge: edge=1 & EN=1 & CH_MASK!=0.
- Latency: all output updates for an edge occur on the CLK edge SYNC_STAGES edges after the edge that first samples V_SYNC high. FRAME_TICK pulses high for exactly that one cycle.
- States: IDLE, GUARD, ON.
- IDLE:
  - SYNC=0.
  - On an accepted edge: ch <= lowest set bit of CH_MASK, fcnt <= 0. Go to GUARD if GUARD_CYCLES>0, else go to ON.
- Advance rule, applied on an accepted edge in GUARD or ON:
  - If fcnt==FRAMES_PER_CH-1: fcnt <= 0 and ch <= next set mask bit, searching ch+1 upward with wrap N_CH-1 -> 0.
  - If ch is the only set bit, ch is unchanged.
  - Otherwise fcnt <= fcnt+1.
  - Next state: GUARD (guard counter reloads) if GUARD_CYCLES>0, else ON.
- Edge during GUARD: advance is applied and the guard restarts from the full count.
- GUARD: SYNC=0 for exactly GUARD_CYCLES cycles, then go to ON.
- ON: SYNC = onehot(ch) & CH_MASK, registered.
  - Clearing the current channel's mask bit drops SYNC to 0 on the next cycle. ch is kept until the next edge.
- Empty mask: an edge with EN=1 and CH_MASK==0 returns to IDLE next cycle, with SYNC=0, CUR_CH=0 and no FRAME_TICK.
- EN=0: from any state, on the next CLK edge go to IDLE with SYNC=0, CUR_CH=0, fcnt=0. Edges seen while EN=0 are ignored.
- Break-before-make: SYNC is never multi-hot. Channel changes with GUARD_CYCLES=0 switch old bit off and new bit on in the same cycle.
- Compatibility: N_CH=2, FRAMES_PER_CH=1, GUARD_CYCLES=0, CH_MASK=2'b11 gives strict per-frame alternation 01,10,01,...
- CUR_CH reflects ch in GUARD and ON.

Test Plan:
1. N_CH=2, F=1, G=0, mask=11, EN=1, five V_SYNC pulses -> SYNC 01,10,01,10,01. Each change occurs SYNC_STAGES CLK edges after the sampling edge. FRAME_TICK pulses 5 times. CUR_CH 0,1,0,1,0.
2. N_CH=4, F=2, mask=1011, eight pulses -> CUR_CH 0,0,1,1,3,3,0,0. SYNC matches one-hot, bit 2 never set.
3. G=3, N_CH=2, mask=11 -> after each edge SYNC=00 for exactly 3 cycles, then the new one-hot. A second edge arriving during guard restarts the 3-cycle guard with the advanced channel.
4. EN dropped mid-ON with ch=1 -> next cycle SYNC=0, CUR_CH=0, pulses during EN=0 give no FRAME_TICK. Re-enable with mask=0110, next edge -> CUR_CH=1, SYNC=0010.
5. V_SYNC held high across RST_N release -> no FRAME_TICK until V_SYNC goes low then high. RST_N asserted while SYNC=10 -> SYNC=00 without a CLK edge.
6. Mask 11 to 10 while ch=0 in ON -> SYNC=00 next cycle; next edge -> CUR_CH=1, SYNC=10. Mask=00 at the following edge -> IDLE, SYNC=00, no FRAME_TICK.
